// File: rtl/dmem_arbiter.sv
// Round-robin two-port controller for a single-port word-wide data memory.
// Byte/half/word accesses map onto word accesses; sub-word stores use read-modify-write.
module dmem_arbiter #(
   parameter int N = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic [31:0]          p0_addr,
   input  logic [1:0]           p0_size,
   input  logic                 p0_uns,
   input  logic [31:0]          p0_wdata,
   output logic                 p0_gnt,
   output logic                 p0_done,
   output logic [31:0]          p0_rdata,
   output logic                 p0_err,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic [31:0]          p1_addr,
   input  logic [1:0]           p1_size,
   input  logic                 p1_uns,
   input  logic [31:0]          p1_wdata,
   output logic                 p1_gnt,
   output logic                 p1_done,
   output logic [31:0]          p1_rdata,
   output logic                 p1_err,
   output logic [$clog2(N)-1:0] mem_a,
   output logic [31:0]          mem_wd,
   output logic                 mem_we,
   input  logic [31:0]          mem_rd
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, WRITEBACK} state_t;

   state_t          state;
   logic            last_gnt;
   logic            owner;
   logic            lat_we;
   logic [1:0]      lat_size;
   logic            lat_uns;
   logic [31:0]     lat_wdata;
   logic [IW-1:0]   lat_idx;
   logic [1:0]      lat_lane;
   logic            lat_err;
   logic [31:0]     merged;

   logic            sel_we;
   logic [31:0]     sel_addr;
   logic [1:0]      sel_size;
   logic            sel_uns;
   logic [31:0]     sel_wdata;
   logic            word_st;
   logic            done_any;
   logic [31:0]     rdata_any;
   logic            err_any;

   function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] size);
      logic bad_align;
      bad_align = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
      return (size == 2'b11) || bad_align || ((addr >> (IW + 2)) != 32'd0);
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{lane, 3'b000} +: 8];
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b00:   return {{24{b[7] & ~uns}}, b};
         2'b01:   return {{16{h[15] & ~uns}}, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] merge_sub(input logic [31:0] rd, input logic [15:0] wd,
                                             input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] m;
      m = rd;
      if (size == 2'b00)
         m[{lane, 3'b000} +: 8] = wd[7:0];
      else if (lane[1])
         m[31:16] = wd;
      else
         m[15:0] = wd;
      return m;
   endfunction

   // Grant only from IDLE; on a tie the port not granted last wins.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (state == IDLE) begin
         if (p0_req && p1_req) begin
            p0_gnt = last_gnt;
            p1_gnt = ~last_gnt;
         end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
         end
      end
   end

   assign sel_we    = p1_gnt ? p1_we    : p0_we;
   assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
   assign sel_size  = p1_gnt ? p1_size  : p0_size;
   assign sel_uns   = p1_gnt ? p1_uns   : p0_uns;
   assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         owner    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (p0_gnt || p1_gnt) begin
               state    <= ACCESS;
               owner    <= p1_gnt;
               last_gnt <= p1_gnt;
            end
            ACCESS:    state <= (lat_err || word_st) ? IDLE : CAPTURE;
            CAPTURE:   state <= lat_we ? WRITEBACK : IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // Request fields and the merge word carry no reset; every use is gated by state.
   always_ff @(posedge clk) begin
      if (p0_gnt || p1_gnt) begin
         lat_we    <= sel_we;
         lat_size  <= sel_size;
         lat_uns   <= sel_uns;
         lat_wdata <= sel_wdata;
         lat_idx   <= sel_addr[IW+1:2];
         lat_lane  <= sel_addr[1:0];
         lat_err   <= addr_err(sel_addr, sel_size);
      end
      if (state == CAPTURE && lat_we)
         merged <= merge_sub(mem_rd, lat_wdata[15:0], lat_lane, lat_size);
   end

   assign word_st   = lat_we && (lat_size == 2'b10);
   assign done_any  = (state == ACCESS && (lat_err || word_st)) ||
                      (state == CAPTURE && !lat_we) || (state == WRITEBACK);
   assign err_any   = (state == ACCESS) && lat_err;
   assign rdata_any = (state == CAPTURE && !lat_we) ?
                      load_ext(mem_rd, lat_lane, lat_size, lat_uns) : 32'd0;

   assign p0_done  = done_any && !owner;
   assign p1_done  = done_any &&  owner;
   assign p0_err   = err_any  && !owner;
   assign p1_err   = err_any  &&  owner;
   assign p0_rdata = owner ? 32'd0 : rdata_any;
   assign p1_rdata = owner ? rdata_any : 32'd0;

   assign mem_a  = ((state == ACCESS && !lat_err) || state == CAPTURE || state == WRITEBACK) ?
                   lat_idx : '0;
   assign mem_we = (state == ACCESS && !lat_err && word_st) || (state == WRITEBACK);
   assign mem_wd = (state == ACCESS && !lat_err && word_st) ? lat_wdata :
                   (state == WRITEBACK) ? merged : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory and
// a byte-level reference model of loads, stores, errors and round-robin grants.
module tb_dmem_arbiter;
   localparam int N  = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_req = 1'b0, p0_we = 1'b0, p0_uns = 1'b0;
   logic [31:0]   p0_addr = '0, p0_wdata = '0;
   logic [1:0]    p0_size = '0;
   logic          p1_req = 1'b0, p1_we = 1'b0, p1_uns = 1'b0;
   logic [31:0]   p1_addr = '0, p1_wdata = '0;
   logic [1:0]    p1_size = '0;
   logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
   logic [31:0]   p0_rdata, p1_rdata;
   logic [AW-1:0] mem_a;
   logic [31:0]   mem_wd, mem_rd;
   logic          mem_we;

   always #5 clk = ~clk;

   dmem_arbiter #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
      .p0_uns(p0_uns), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
      .p1_uns(p1_uns), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   typedef struct {logic [31:0] rdata; logic err; int due;} resp_t;
   typedef struct {logic [AW-1:0] a; logic [31:0] d; int due;} wr_t;

   logic [31:0] tbmem  [N];
   logic [31:0] refmem [N];
   logic        seeded = 1'b0;
   resp_t       rq0[$], rq1[$];
   wr_t         wq[$];
   int          checks = 0, errors = 0, cyc = 0, last_gnt = 1;
   int          pend_idx = 0;
   logic [31:0] pend_old = '0;

   // Memory with one-cycle registered read; seeded once during the first reset.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n && !seeded) begin
         for (int i = 0; i < N; i++) tbmem[i] <= 32'(i) * 32'h9E3779B1;
         seeded <= 1'b1;
      end else begin
         mem_rd <= tbmem[mem_a];
         if (mem_we) tbmem[mem_a] <= mem_wd;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model(input int port, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wd);
      int nb, idx, off;
      logic [63:0] mask;
      logic [31:0] val;
      resp_t r;
      wr_t w;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      r.rdata = 32'd0;
      r.err = (size == 2'd3) || (addr % nb != 0) || (addr >= 32'(4 * N));
      r.due = cyc + 1;
      if (!r.err) begin
         idx  = int'(addr / 4);
         off  = int'(addr % 4);
         mask = (64'd1 << (8 * nb)) - 64'd1;
         if (!we) begin
            val = 32'((64'(refmem[idx]) >> (8 * off)) & mask);
            if (!uns && nb < 4 && val[8*nb-1]) val = val | ~32'(mask);
            r.rdata = val;
            r.due   = cyc + 2;
         end else begin
            pend_idx = idx;
            pend_old = refmem[idx];
            refmem[idx] = 32'((64'(refmem[idx]) & ~(mask << (8 * off))) |
                              ((64'(wd) & mask) << (8 * off)));
            r.due = cyc + ((nb == 4) ? 1 : 3);
            w.a = AW'(idx);
            w.d = refmem[idx];
            w.due = r.due;
            wq.push_back(w);
         end
      end
      if (port == 0) rq0.push_back(r);
      else rq1.push_back(r);
   endfunction

   // Monitor: responses, memory writes and arbitration, sampled on the falling edge.
   always @(negedge clk) begin : monitor
      resp_t r;
      wr_t w;
      if (!rst_n) begin
         rq0.delete();
         rq1.delete();
         wq.delete();
         last_gnt = 1;
      end else begin
         if (p0_done) begin
            if (rq0.size() == 0) chk("p0_unexpected_done", 32'd1, 32'd0);
            else begin
               r = rq0.pop_front();
               chk("p0_rdata", p0_rdata, r.rdata);
               chk("p0_err", {31'd0, p0_err}, {31'd0, r.err});
               chk("p0_latency", cyc, r.due);
            end
         end else chk("p0_quiet", p0_rdata | {31'd0, p0_err}, 32'd0);
         if (p1_done) begin
            if (rq1.size() == 0) chk("p1_unexpected_done", 32'd1, 32'd0);
            else begin
               r = rq1.pop_front();
               chk("p1_rdata", p1_rdata, r.rdata);
               chk("p1_err", {31'd0, p1_err}, {31'd0, r.err});
               chk("p1_latency", cyc, r.due);
            end
         end else chk("p1_quiet", p1_rdata | {31'd0, p1_err}, 32'd0);
         if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_mem_we", 32'd1, 32'd0);
            else begin
               w = wq.pop_front();
               chk("mem_a", 32'(mem_a), 32'(w.a));
               chk("mem_wd", mem_wd, w.d);
               chk("mem_we_cycle", cyc, w.due);
            end
         end
         if (p0_gnt || p1_gnt) begin
            chk("gnt_onehot", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            chk("gnt_has_req", {31'd0, p1_gnt ? p1_req : p0_req}, 32'd1);
            if (p0_req && p1_req)
               chk("tie_winner", {31'd0, p1_gnt}, (last_gnt == 0) ? 32'd1 : 32'd0);
            last_gnt = p1_gnt ? 1 : 0;
         end
      end
   end

   // Called at posedge+1; holds the request until granted, drops it at the next posedge+1.
   task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wd,
                         output int waited);
      logic g;
      waited = 0;
      g = 1'b0;
      if (port == 0) begin
         p0_we = we; p0_addr = addr; p0_size = size; p0_uns = uns; p0_wdata = wd; p0_req = 1'b1;
      end else begin
         p1_we = we; p1_addr = addr; p1_size = size; p1_uns = uns; p1_wdata = wd; p1_req = 1'b1;
      end
      while (!g && waited < 200) begin
         @(negedge clk);
         g = (port == 0) ? p0_gnt : p1_gnt;
         if (g) model(port, we, addr, size, uns, wd);
         else waited++;
      end
      if (!g) chk("gnt_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (port == 0) p0_req = 1'b0;
      else p1_req = 1'b0;
   endtask

   task automatic rand_port(input int port, input int n);
      int w, r, g;
      logic [31:0] a;
      logic [1:0] sz;
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(0, 2);
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
         r  = $urandom_range(0, 15);
         sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
         a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
         do_req(port, 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, w);
      end
   endtask

   initial begin
      int w, w2;
      for (int i = 0; i < N; i++) refmem[i] = 32'(i) * 32'h9E3779B1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset_mem_a", 32'(mem_a), 32'd0);
      chk("reset_done", {30'd0, p0_done, p1_done}, 32'd0);
      rst_n = 1'b1;

      // Tie from reset: grants must alternate starting with port 0.
      fork
         begin do_req(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, w);  do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, w);  end
         begin do_req(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, w2); do_req(1, 1'b0, 32'hC, 2'd2, 1'b0, 32'h0, w2); end
      join

      do_req(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, w);
      do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, w);
      do_req(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h80FF7F01, w);
      do_req(0, 1'b0, 32'h12, 2'd0, 1'b0, 32'h0, w);
      do_req(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, w);
      do_req(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, w);
      do_req(1, 1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, w);
      do_req(1, 1'b1, 32'h12, 2'd1, 1'b0, 32'h0000ABCD, w);
      do_req(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, w);
      do_req(0, 1'b0, 32'h2, 2'd2, 1'b0, 32'h0, w);
      do_req(1, 1'b1, 32'h1, 2'd1, 1'b0, 32'h1234, w);
      do_req(0, 1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, w);
      do_req(1, 1'b1, 32'h0, 2'd3, 1'b0, 32'hFFFFFFFF, w);

      // Abort a byte store in its CAPTURE cycle; the write must never appear.
      do_req(0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h5A, w);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
      chk("abort_mem_a", 32'(mem_a), 32'd0);
      chk("abort_mem_wd", mem_wd, 32'd0);
      chk("abort_outputs", {28'd0, p0_done, p0_err, p1_done, p1_err} | p0_rdata | p1_rdata, 32'd0);
      refmem[pend_idx] = pend_old;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_req(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, w);
      chk("rst_first_gnt_wait", 32'(w), 32'd0);

      fork
         rand_port(0, 120);
         rand_port(1, 120);
      join

      for (int i = 0; i < 20 && (rq0.size() + rq1.size() + wq.size()) != 0; i++)
         @(posedge clk);
      @(negedge clk);
      chk("drain_p0", 32'(rq0.size()), 32'd0);
      chk("drain_p1", 32'(rq1.size()), 32'd0);
      chk("drain_wr", 32'(wq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
